gray_step_monitor: RTL and testbench
====================================

// Module: gray_step_monitor
// PURPOSE
//  Downstream consumer of the binary-to-Gray converter output.
//  Registers each incoming Gray code and decodes it back to binary.
//  Classifies every sample against the previous one as step-up, step-down, hold or illegal jump.
//  Keeps a saturating error count. Used as an encoder/pointer sanity monitor.
// PARAMETERS
//  WIDTH      4  Gray/binary code width in bits (>=2)
//  ERR_CNT_W  8  width of saturating illegal-jump counter
// PORTS
//  clk        input   1          single clock, all logic on posedge
//  rst        input   1          synchronous, active-high reset
//  enb        input   1          monitor enable; low = outputs forced 0, lock dropped
//  in_valid   input   1          in_gray is valid this cycle
//  in_gray    input   WIDTH      Gray code sample (reflected binary Gray)
//  out_valid  output  1          registered: decoded sample available
//  out_bin    output  WIDTH      binary value of last accepted sample
//  step_up    output  1          1-cycle pulse: sample == prev+1 (mod 2^WIDTH)
//  step_dn    output  1          1-cycle pulse: sample == prev-1 (mod 2^WIDTH)
//  step_err   output  1          1-cycle pulse: sample differs from prev by other than 0/+-1
//  err_cnt    output  ERR_CNT_W  saturating count of step_err pulses
//  locked     output  1          a reference sample is held (state LOCKED)
//  pos_cnt    output  16         signed position, only with GRAY_MON_POS_EN
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0, state UNLOCKED, prev ref 0. rst overrides enb/in_valid.
//  - Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i], i=W-2..0. Comb decode, then registered.
//  - Latency: one cycle. Sample accepted at edge N appears on out_* at edge N (visible in cycle N+1).
//  - out_valid = registered (enb & in_valid). out_bin updates only on accepted samples, else holds.
//  - step_up/step_dn/step_err are registered pulses, high 1 cycle. At most one high at a time.
//  - FSM, 2 states:
//    UNLOCKED: accepted sample -> store as prev, out_bin=value, no step flag, go LOCKED.
//    LOCKED:   accepted sample -> d = bin - prev (mod 2^WIDTH):
//        d==0        : hold, no flag
//        d==1        : step_up (wrap 2^W-1 -> 0 is step_up)
//        d==all-ones : step_dn (wrap 0 -> 2^W-1 is step_dn)
//        otherwise   : step_err, err_cnt+1
//      In every case prev <= bin; stay LOCKED (re-sync on the new value after an error).
//    Any state, enb=0 -> UNLOCKED next edge.
//  - in_valid=0 with enb=1: no state change, flags 0, out_valid 0, out_bin holds.
//  - enb=0: out_valid, out_bin, flags forced 0 at next edge (mirrors converter enb=0 -> y=0).
//    locked=0. err_cnt and pos_cnt hold; they are cleared only by rst.
//  - err_cnt saturates at 2^ERR_CNT_W-1. Further errors still pulse step_err; count does not wrap.
// CONFIGURATION
//  GRAY_MON_POS_EN defined:
//    pos_cnt port exists, signed 16-bit, reset 0.
//    +1 on step_up, -1 on step_dn, unchanged on hold/error/unlock.
//    Wraps in two's complement at +32767/-32768.
//  GRAY_MON_POS_EN undefined:
//    pos_cnt port and its logic are absent. All other behaviour is identical.
// TESTING (WIDTH=4, ERR_CNT_W=8)
//  1. rst 2 cycles, enb=1, in_gray=0000 valid
//     -> next cycle out_valid=1, out_bin=0, locked=1, no step flag
//  2. in_gray 0000,0001,0011,0010 back-to-back
//     -> out_bin 0,1,2,3; step_up on 2nd-4th outputs; pos_cnt=3 if GRAY_MON_POS_EN
//  3. Wrap: 1000 (bin 15) then 0000 -> step_up. Then 0000 then 1000 -> step_dn.
//  4. Illegal jump: 0001 then 0110 (bin 4) -> step_err=1, err_cnt 0->1.
//     Next 0111 (bin 5) -> step_up, no error.
//     300 alternating 0000/0110 samples -> err_cnt stops at 255.
//  5. enb dropped for 1 cycle mid-stream -> next cycle out_bin=0, flags 0, locked=0, err_cnt held.
//     First sample after enb=1 -> no step flag, locked=1.
//  6. rst=1 together with in_valid=1, in_gray=0001 -> all outputs 0, locked=0; sample ignored.

Source files
------------

// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: registers and decodes Gray samples, classifies each step, counts illegal jumps.
// Optional signed position counter on pos_cnt when GRAY_MON_POS_EN is defined.
module gray_step_monitor #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enb,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_gray,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_bin,
   output logic                 step_up,
   output logic                 step_dn,
   output logic                 step_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 locked
`ifdef GRAY_MON_POS_EN
   ,output logic signed [15:0]  pos_cnt
`endif
);

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     prev, prev_nxt;
   logic [WIDTH-1:0]     bin, delta;
   logic [WIDTH-1:0]     out_bin_nxt;
   logic                 out_valid_nxt, up_nxt, dn_nxt, err_nxt;
   logic [ERR_CNT_W-1:0] err_cnt_nxt;
`ifdef GRAY_MON_POS_EN
   logic signed [15:0]   pos_nxt;
`endif

   always_comb begin
      bin = '0;
      bin[WIDTH-1] = in_gray[WIDTH-1];
      // Walk from MSB towards LSB: each binary bit folds in the one above it.
      for (int unsigned i = 1; i < WIDTH; i++) begin
         bin[WIDTH-1-i] = bin[WIDTH-i] ^ in_gray[WIDTH-1-i];
      end
   end

   assign delta = bin - prev;

   always_comb begin
      state_nxt     = state;
      prev_nxt      = prev;
      out_bin_nxt   = out_bin;
      out_valid_nxt = 1'b0;
      up_nxt        = 1'b0;
      dn_nxt        = 1'b0;
      err_nxt       = 1'b0;
      err_cnt_nxt   = err_cnt;
`ifdef GRAY_MON_POS_EN
      pos_nxt       = pos_cnt;
`endif
      if (!enb) begin
         state_nxt   = UNLOCKED;
         out_bin_nxt = '0;
      end else if (in_valid) begin
         out_valid_nxt = 1'b1;
         out_bin_nxt   = bin;
         prev_nxt      = bin;
         if (state == UNLOCKED) begin
            state_nxt = LOCKED;
         end else if (delta == '0) begin
            up_nxt = 1'b0;
         end else if (delta == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            up_nxt = 1'b1;
`ifdef GRAY_MON_POS_EN
            pos_nxt = pos_cnt + 16'sd1;
`endif
         end else if (delta == '1) begin
            dn_nxt = 1'b1;
`ifdef GRAY_MON_POS_EN
            pos_nxt = pos_cnt - 16'sd1;
`endif
         end else begin
            err_nxt = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= UNLOCKED;
         prev      <= '0;
         out_valid <= 1'b0;
         out_bin   <= '0;
         step_up   <= 1'b0;
         step_dn   <= 1'b0;
         step_err  <= 1'b0;
         err_cnt   <= '0;
`ifdef GRAY_MON_POS_EN
         pos_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         prev      <= prev_nxt;
         out_valid <= out_valid_nxt;
         out_bin   <= out_bin_nxt;
         step_up   <= up_nxt;
         step_dn   <= dn_nxt;
         step_err  <= err_nxt;
         err_cnt   <= err_cnt_nxt;
`ifdef GRAY_MON_POS_EN
         pos_cnt   <= pos_nxt;
`endif
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed self-checking bench for gray_step_monitor (WIDTH=4, ERR_CNT_W=8).
module tb_gray_step_monitor;

   logic       clk = 1'b0;
   logic       rst, enb, in_valid;
   logic [3:0] in_gray;
   logic       out_valid, step_up, step_dn, step_err, locked;
   logic [3:0] out_bin;
   logic [7:0] err_cnt;
`ifdef GRAY_MON_POS_EN
   logic signed [15:0] pos_cnt;
`endif
   logic [15:0] exp_pos;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   gray_step_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_gray(in_gray),
      .out_valid(out_valid), .out_bin(out_bin), .step_up(step_up), .step_dn(step_dn),
      .step_err(step_err), .err_cnt(err_cnt), .locked(locked)
`ifdef GRAY_MON_POS_EN
      , .pos_cnt(pos_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs just after an edge; outputs are then settled for that sample.
   task automatic cyc(input logic r, input logic e, input logic v, input logic [3:0] g);
      rst = r; enb = e; in_valid = v; in_gray = g;
      @(posedge clk);
      #1;
   endtask

   // flags packed as {step_up, step_dn, step_err}
   task automatic expect_out(input string tag, input logic v, input logic [3:0] b,
                             input logic [2:0] fl, input logic lk, input logic [7:0] ec);
      check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
      check({tag, ".bin"},   {28'b0, out_bin},   {28'b0, b});
      check({tag, ".flags"}, {29'b0, step_up, step_dn, step_err}, {29'b0, fl});
      check({tag, ".locked"},{31'b0, locked},    {31'b0, lk});
      check({tag, ".errcnt"},{24'b0, err_cnt},   {24'b0, ec});
`ifdef GRAY_MON_POS_EN
      check({tag, ".pos"},   {16'b0, pos_cnt},   {16'b0, exp_pos});
`endif
   endtask

   initial begin
      int unsigned exp_ec;
      exp_pos = 16'd0;
      rst = 1'b1; enb = 1'b0; in_valid = 1'b0; in_gray = 4'b0000;
      cyc(1, 0, 0, 4'b0000);
      cyc(1, 0, 0, 4'b0000);
      expect_out("reset", 0, 4'd0, 3'b000, 0, 8'd0);

      cyc(0, 1, 1, 4'b0000);
      expect_out("lock0", 1, 4'd0, 3'b000, 1, 8'd0);

      cyc(0, 1, 1, 4'b0000); expect_out("hold0", 1, 4'd0, 3'b000, 1, 8'd0);
      cyc(0, 1, 1, 4'b0001); exp_pos = 16'd1; expect_out("up1", 1, 4'd1, 3'b100, 1, 8'd0);
      cyc(0, 1, 1, 4'b0011); exp_pos = 16'd2; expect_out("up2", 1, 4'd2, 3'b100, 1, 8'd0);
      cyc(0, 1, 1, 4'b0010); exp_pos = 16'd3; expect_out("up3", 1, 4'd3, 3'b100, 1, 8'd0);

      cyc(0, 1, 0, 4'b1111); expect_out("idle", 0, 4'd3, 3'b000, 1, 8'd0);

      // Unlock so bin 15 can become the new reference without an error
      cyc(0, 0, 0, 4'b0000); expect_out("unlock", 0, 4'd0, 3'b000, 0, 8'd0);
      cyc(0, 1, 1, 4'b1000); expect_out("relock15", 1, 4'd15, 3'b000, 1, 8'd0);
      cyc(0, 1, 1, 4'b0000); exp_pos = 16'd4; expect_out("wrapup", 1, 4'd0, 3'b100, 1, 8'd0);
      cyc(0, 1, 1, 4'b0000); expect_out("hold1", 1, 4'd0, 3'b000, 1, 8'd0);
      cyc(0, 1, 1, 4'b1000); exp_pos = 16'd3; expect_out("wrapdn", 1, 4'd15, 3'b010, 1, 8'd0);

      cyc(0, 1, 1, 4'b0000); exp_pos = 16'd4; expect_out("up0", 1, 4'd0, 3'b100, 1, 8'd0);
      cyc(0, 1, 1, 4'b0001); exp_pos = 16'd5; expect_out("up1b", 1, 4'd1, 3'b100, 1, 8'd0);
      cyc(0, 1, 1, 4'b0110); expect_out("jump", 1, 4'd4, 3'b001, 1, 8'd1);
      cyc(0, 1, 1, 4'b0111); exp_pos = 16'd6; expect_out("resync", 1, 4'd5, 3'b100, 1, 8'd1);

      for (int i = 0; i < 300; i++) begin
         exp_ec = (i + 2 > 255) ? 255 : i + 2;
         if (i % 2 == 0) begin
            cyc(0, 1, 1, 4'b0000);
            expect_out("sat", 1, 4'd0, 3'b001, 1, exp_ec[7:0]);
         end else begin
            cyc(0, 1, 1, 4'b0110);
            expect_out("sat", 1, 4'd4, 3'b001, 1, exp_ec[7:0]);
         end
      end

      cyc(0, 0, 1, 4'b0001); expect_out("enboff", 0, 4'd0, 3'b000, 0, 8'd255);
      cyc(0, 1, 1, 4'b0001); expect_out("enbon", 1, 4'd1, 3'b000, 1, 8'd255);
      cyc(0, 1, 1, 4'b0011); exp_pos = 16'd7; expect_out("enbup", 1, 4'd2, 3'b100, 1, 8'd255);

      cyc(1, 1, 1, 4'b0001); exp_pos = 16'd0; expect_out("rstvalid", 0, 4'd0, 3'b000, 0, 8'd0);
      cyc(0, 1, 1, 4'b0011); expect_out("postrst", 1, 4'd2, 3'b000, 1, 8'd0);
      cyc(0, 1, 1, 4'b0011); expect_out("posthold", 1, 4'd2, 3'b000, 1, 8'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
